// File: rtl/store_buffer_unit.sv
// Store alignment plus a DEPTH-entry posted-store FIFO feeding the data-memory port.
// Optional misalignment/legality rejection is enabled by defining STORE_BUF_MISALIGN_CHK_EN.
module store_buffer_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [1:0]                funct3_in,
  input  logic [AW-1:0]             iadder_in,
  input  logic [XLEN-1:0]           rs2_in,
  input  logic                      mem_wr_req_in,
  output logic                      st_ready_out,
  output logic                      st_err_out,
  output logic [XLEN-1:0]           dmdata_out,
  output logic [AW-1:0]             dmaddr_out,
  output logic [XLEN/8-1:0]         dmwr_mask_out,
  output logic                      dmwr_req_out,
  input  logic                      dm_ready_in,
  output logic                      empty_out,
  output logic [$clog2(DEPTH):0]    count_out
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [1:0]      w_f3;
  logic [3:0]      w_off_ext;
  logic [NB-1:0]   w_keep;
  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_low;
  logic [XLEN-1:0] w_data;
  logic [AW-1:0]   w_addr;
  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;

  logic [XLEN-1:0] r_data [DEPTH];
  logic [AW-1:0]   r_addr [DEPTH];
  logic [NB-1:0]   r_mask [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // A double store on a 32-bit core degrades to a word store; shifted lanes past NB fall off.
  always_comb begin
    w_f3 = funct3_in;
    if (XLEN == 32 && funct3_in == 2'b11) w_f3 = 2'b10;
    w_off_ext = 4'(iadder_in[OB-1:0]);
    for (int unsigned i = 0; i < NB; i++) begin
      w_keep[i]         = (i < (32'd1 << w_f3));
      w_low[8*i +: 8]   = w_keep[i] ? rs2_in[8*i +: 8] : 8'h00;
    end
    w_data = w_low << {w_off_ext, 3'b000};
    w_mask = w_keep << w_off_ext;
    w_addr = {iadder_in[AW-1:OB], {OB{1'b0}}};
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_deq   = !w_empty && dm_ready_in;

`ifdef STORE_BUF_MISALIGN_CHK_EN
  logic w_legal;
  logic w_aligned;
  logic r_err;

  always_comb begin
    w_legal = (funct3_in != 2'b11) || (XLEN == 64);
    unique case (w_f3)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = (w_off_ext[0] == 1'b0);
      2'b10:   w_aligned = (w_off_ext[1:0] == 2'b00);
      default: w_aligned = (w_off_ext[2:0] == 3'b000);
    endcase
  end

  assign w_enq = mem_wr_req_in && !w_full && w_legal && w_aligned;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_err <= 1'b0;
    else           r_err <= mem_wr_req_in && !w_full && !(w_legal && w_aligned);
  end

  assign st_err_out = r_err;
`else
  assign w_enq      = mem_wr_req_in && !w_full;
  assign st_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_data[r_wptr] <= w_data;
        r_addr[r_wptr] <= w_addr;
        r_mask[r_wptr] <= w_mask;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head outputs read zero when nothing is pending.
  assign dmdata_out    = w_empty ? '0 : r_data[r_rptr];
  assign dmaddr_out    = w_empty ? '0 : r_addr[r_rptr];
  assign dmwr_mask_out = w_empty ? '0 : r_mask[r_rptr];
  assign dmwr_req_out  = !w_empty;
  assign empty_out     = w_empty;
  assign st_ready_out  = !w_full;
  assign count_out     = r_count;

endmodule
